dmem_ctrl: RTL

- Data-memory controller downstream of the MEM stage of the 5-stage RISC-V pipeline.
- Consumes the MEM stage's chip-enable, write-enable, address and store-data outputs.
- Performs word accesses to an internal single-port RAM with a configurable number of wait states.
- Returns load data to the MEM stage's memory-data input, and raises a stall to the pipeline while an access is in flight.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_ram.sv | 23 ++
 rtl/dmem_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller and the MEM stage.
// Holds the controller state encoding, alignment constants and the lw/sw ALU op codes.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          WORD_BYTES = 4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;
    localparam logic [4:0]  ALUOP_LW   = 5'b10100;
    localparam logic [4:0]  ALUOP_SW   = 5'b10101;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM; a write takes priority over the read.
// rdata is registered on every edge that does not write.
module dmem_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: word accesses with LATENCY wait states, stall while busy.
// Stall_o covers the accept cycle plus LATENCY busy cycles; the DONE cycle releases the pipeline.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemCE_i,
    input  logic        MemWE_i,
    input  logic [31:0] MemAddr_i,
    input  logic [31:0] MemData_i,
    output logic [31:0] RdData_o,
    output logic        Stall_o,
    output logic        Err_o
);

    state_t              state;
    logic [3:0]          cnt;
    logic                we_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic [31:0]         ram_rdata;
    logic [ADDR_W-1:0]   idx_in;
    logic [ADDR_W-1:0]   ram_addr;
    logic                misaligned;
    logic                accept;
    logic                last_busy;
    logic                ram_we;
    logic                addr_hi_unused;

    // Upper address bits are deliberately dropped so the address space wraps.
    assign idx_in         = MemAddr_i[ADDR_W+1:2];
    assign addr_hi_unused = ^MemAddr_i[31:ADDR_W+2];

    assign misaligned = is_misaligned(MemAddr_i);
    assign accept     = (state == ST_IDLE) && MemCE_i && !misaligned;
    assign last_busy  = (state == ST_BUSY) && (cnt == 4'd0);

    assign Err_o   = !rst && (state == ST_IDLE) && MemCE_i && misaligned;
    assign Stall_o = !rst && ((state == ST_BUSY) || accept);

    // The RAM reads the incoming index while idle so the word is already
    // registered by the final busy edge, whatever LATENCY is.
    assign ram_addr = (state == ST_IDLE) ? idx_in : idx_q;
    assign ram_we   = last_busy && we_q && !rst;

    dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= 32'd0;
            RdData_o <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        we_q    <= MemWE_i;
                        idx_q   <= idx_in;
                        wdata_q <= MemData_i;
                        cnt     <= 4'(LATENCY - 1);
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!we_q) begin
                            RdData_o <= ram_rdata;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
